// File: rtl/vga_seq_pkg.sv
// Shared types and constants for the VGA mode sequencer.
// State encoding, blanking levels and RGB pack/unpack helpers.
package vga_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP_A,
    S_RUN_A,
    S_GUARD,
    S_PREP_B,
    S_RUN_B,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic        SYNC_IDLE = 1'b1;
  localparam logic [23:0] RGB_BLANK = 24'h0;

  function automatic logic [23:0] pack_rgb(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {r, g, b};
  endfunction

  function automatic rgb_t unpack_rgb(input logic [23:0] v);
    return rgb_t'(v);
  endfunction

endpackage

// File: rtl/vga_clk_enable.sv
// Pixel clock enable: one-cycle en every DIV cycles while run is high.
// Ports: clk, rst (sync, active-high), clr (zero divider), run, en.
module vga_clk_enable #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic en
);

  localparam logic [3:0] LAST = 4'(DIV - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 4'd0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? 4'd0 : cnt + 4'd1;
    end
  end

  // Fires when the divider reaches its last count, so the first
  // pulse lands DIV cycles into a run.
  assign en = run && (cnt == LAST);

endmodule

// File: rtl/vga_mode_sequencer.sv
// Sequences the 640 (A) and 320 (B) VGA generators onto one output bus.
// Ports: clk, rst, start, a_/b_ generator inputs, a_en/b_en, a_rst/b_rst,
// Hsync/Vsync/R/G/B output bus, sel_b, DONE640, DONE, busy.
module vga_mode_sequencer
  import vga_seq_pkg::*;
#(
  parameter int FRAMES_A     = 1,
  parameter int FRAMES_B     = 1,
  parameter int DIV_A        = 1,
  parameter int DIV_B        = 2,
  parameter int GUARD_CYCLES = 4,
  parameter int LOOP         = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       a_done,
  input  logic       b_done,
  input  logic       a_hsync,
  input  logic       a_vsync,
  input  logic [7:0] a_r,
  input  logic [7:0] a_g,
  input  logic [7:0] a_b,
  input  logic       b_hsync,
  input  logic       b_vsync,
  input  logic [7:0] b_r,
  input  logic [7:0] b_g,
  input  logic [7:0] b_b,
  output logic       a_en,
  output logic       b_en,
  output logic       a_rst,
  output logic       b_rst,
  output logic       Hsync,
  output logic       Vsync,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       sel_b,
  output logic       DONE640,
  output logic       DONE,
  output logic       busy
);

  localparam logic [7:0] LAST_A = 8'(FRAMES_A - 1);
  localparam logic [7:0] LAST_B = 8'(FRAMES_B - 1);
  localparam logic [7:0] LAST_G = 8'(GUARD_CYCLES - 1);

  state_t      state;
  state_t      state_d;
  logic [7:0]  frame_cnt;
  logic [7:0]  guard_cnt;
  logic        done640_q;
  logic        hs_q;
  logic        vs_q;
  logic [23:0] rgb_q;
  rgb_t        rgb_out;
  logic        prep_a;
  logic        prep_b;
  logic        run_a;
  logic        run_b;

  assign prep_a = (state == S_PREP_A);
  assign prep_b = (state == S_PREP_B);
  assign run_a  = (state == S_RUN_A);
  assign run_b  = (state == S_RUN_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    a_rst   = 1'b1;
    b_rst   = 1'b1;
    sel_b   = 1'b0;
    busy    = 1'b1;
    DONE    = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_PREP_A;
      end
      S_PREP_A: state_d = S_RUN_A;
      S_RUN_A: begin
        a_rst = 1'b0;
        if (a_done && frame_cnt == LAST_A) state_d = S_GUARD;
      end
      S_GUARD: begin
        if (guard_cnt == LAST_G) state_d = S_PREP_B;
      end
      S_PREP_B: begin
        sel_b   = 1'b1;
        state_d = S_RUN_B;
      end
      S_RUN_B: begin
        sel_b = 1'b1;
        b_rst = 1'b0;
        if (b_done && frame_cnt == LAST_B) begin
          state_d = (LOOP != 0) ? S_PREP_A : S_FINISH;
        end
      end
      S_FINISH: begin
        busy = 1'b0;
        DONE = 1'b1;
        if (start) state_d = S_PREP_A;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // frame_cnt is shared by both phases; each PREP state zeroes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 8'd0;
      guard_cnt <= 8'd0;
      done640_q <= 1'b0;
      hs_q      <= SYNC_IDLE;
      vs_q      <= SYNC_IDLE;
      rgb_q     <= RGB_BLANK;
    end else begin
      if (prep_a || prep_b) begin
        frame_cnt <= 8'd0;
      end else if ((run_a && a_done) || (run_b && b_done)) begin
        frame_cnt <= frame_cnt + 8'd1;
      end

      guard_cnt <= (state == S_GUARD) ? guard_cnt + 8'd1 : 8'd0;

      if (state_d == S_PREP_A) begin
        done640_q <= 1'b0;
      end else if (run_a && state_d == S_GUARD) begin
        done640_q <= 1'b1;
      end

      if (run_a) begin
        hs_q  <= a_hsync;
        vs_q  <= a_vsync;
        rgb_q <= pack_rgb(a_r, a_g, a_b);
      end else if (run_b) begin
        hs_q  <= b_hsync;
        vs_q  <= b_vsync;
        rgb_q <= pack_rgb(b_r, b_g, b_b);
      end else begin
        hs_q  <= SYNC_IDLE;
        vs_q  <= SYNC_IDLE;
        rgb_q <= RGB_BLANK;
      end
    end
  end

  vga_clk_enable #(.DIV(DIV_A)) u_en_a (
    .clk (clk),
    .rst (rst),
    .clr (prep_a),
    .run (run_a),
    .en  (a_en)
  );

  vga_clk_enable #(.DIV(DIV_B)) u_en_b (
    .clk (clk),
    .rst (rst),
    .clr (prep_b),
    .run (run_b),
    .en  (b_en)
  );

  assign rgb_out = unpack_rgb(rgb_q);
  assign Hsync   = hs_q;
  assign Vsync   = vs_q;
  assign R       = rgb_out.r;
  assign G       = rgb_out.g;
  assign B       = rgb_out.b;
  assign DONE640 = done640_q;

endmodule
